// File: rtl/hop_chain_launcher.sv
// hop_chain_launcher
//   Launches a single-cycle pulse into a flop-to-flop hop chain and times its
//   arrival at the chain tail in clock0 cycles. Each measurement is graded
//   against the expected hop count. Pass and fail events are tallied in
//   saturating counters.
//
// Ports
//   clock0      in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   go          in   launch request; honoured only in IDLE
//   chain_in    in   tail of the hop chain
//   launch_out  out  one-cycle pulse into the chain head
//   busy        out  high whenever the FSM is not in IDLE
//   done        out  one-cycle pulse while the result is reported
//   pass        out  last measurement had latency == HOPS
//   latency     out  measured latency of the last measurement
//   pass_cnt    out  saturating count of passing measurements
//   fail_cnt    out  saturating count of mismatches, timeouts and spurious arrivals
module hop_chain_launcher #(
  parameter int HOPS    = 7,
  parameter int TIMEOUT = 15,
  parameter int LAT_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clock0,
  input  logic             rst_n,
  input  logic             go,
  input  logic             chain_in,
  output logic             launch_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [LAT_W-1:0] latency,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, REPORT} state_t;

  localparam logic [LAT_W-1:0] HOPS_L    = LAT_W'(HOPS);
  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic [LAT_W-1:0] latency_nxt;
  logic             pass_nxt;
  logic             pass_inc, fail_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, measurement and event decode.
  // Result increments happen on the edge entering REPORT, so the counters
  // are already updated while done is high. A spurious arrival can never
  // coincide with a result increment: an arrival in WAIT is the result
  // itself.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    latency_nxt = latency;
    pass_nxt    = pass;
    pass_inc    = 1'b0;
    fail_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = LAUNCH;
          cnt_nxt   = '0;
        end
        if (chain_in) fail_inc = 1'b1;
      end
      LAUNCH: begin
        cnt_nxt   = cnt + LAT_W'(1);
        state_nxt = WAIT;
        if (chain_in) fail_inc = 1'b1;
      end
      WAIT: begin
        if (chain_in) begin
          latency_nxt = cnt;
          pass_nxt    = (cnt == HOPS_L);
          state_nxt   = REPORT;
          if (cnt == HOPS_L) pass_inc = 1'b1;
          else               fail_inc = 1'b1;
        end else if (cnt == TIMEOUT_L) begin
          latency_nxt = TIMEOUT_L;
          pass_nxt    = 1'b0;
          fail_inc    = 1'b1;
          state_nxt   = REPORT;
        end else begin
          cnt_nxt = cnt + LAT_W'(1);
        end
      end
      REPORT: begin
        state_nxt = IDLE;
        if (chain_in) fail_inc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs, decoded from the next state so
  // that each output lines up with the cycle its state occupies.
  always_ff @(posedge clock0 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      launch_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      latency    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      launch_out <= (state_nxt == LAUNCH);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == REPORT);
      pass       <= pass_nxt;
      latency    <= latency_nxt;
      if (pass_inc) pass_cnt <= sat_inc(pass_cnt);
      if (fail_inc) fail_cnt <= sat_inc(fail_cnt);
    end
  end

endmodule

// File: tb/tb_hop_chain_launcher.sv
// tb_hop_chain_launcher
//   Directed bench for hop_chain_launcher. A shift-register chain model of
//   selectable length feeds chain_in from launch_out. The chain output can
//   be overridden with a forced level to create timeouts and spurious
//   arrivals.
module tb_hop_chain_launcher;

  logic       clock0;
  logic       rst_n;
  logic       go;
  logic       chain_in;
  logic       launch_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] latency;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Chain model; deliberately not reset, like a real flop chain under test.
  logic [15:0] sr = '0;
  int          chain_len = 7;
  logic        force_en  = 1'b0;
  logic        force_val = 1'b0;

  always @(posedge clock0) sr <= {sr[14:0], launch_out};
  always_comb chain_in = force_en ? force_val : sr[chain_len-1];

  hop_chain_launcher #(.HOPS(7), .TIMEOUT(15), .LAT_W(8), .CNT_W(8)) dut (
    .clock0     (clock0),
    .rst_n      (rst_n),
    .go         (go),
    .chain_in   (chain_in),
    .launch_out (launch_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .latency    (latency),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt)
  );

  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  // Hold reset long enough for the chain model to flush any pulse.
  task automatic do_reset();
    go       = 1'b0;
    force_en = 1'b0;
    rst_n    = 1'b0;
    repeat (20) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    go    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({launch_out, busy, done, pass} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {launch_out, busy, done, pass});
    end
    n_checks++;
    if (latency !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_latency: got %0d expected 0", latency);
    end
    n_checks++;
    if ({pass_cnt, fail_cnt} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", pass_cnt, fail_cnt);
    end
    do_reset();
  endtask

  // Single measurement from a fresh reset. Go is accepted at cycle 0 and
  // the launch cycle is cycle 1.
  task automatic test_measurement(input string name, input int len, input bit tie0,
                                  input int exp_done, input int exp_lat, input bit exp_pass,
                                  input int exp_pc, input int exp_fc);
    int   dcnt;
    int   dcyc;
    logic busy_after;
    logic prev_done;
    do_reset();
    chain_len = len;
    force_en  = tie0;
    force_val = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    n_checks++;
    if ({launch_out, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_launch: got launch/busy %b expected 11", name, {launch_out, busy});
    end
    dcnt = 0;
    dcyc = -1;
    busy_after = 1'bx;
    prev_done = 1'b0;
    for (int c = 2; c <= 30; c++) begin
      tick();
      if (c == 2) begin
        n_checks++;
        if (launch_out !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_launch_width: got %b expected 0 in cycle 2", name, launch_out);
        end
      end
      if (prev_done) busy_after = busy;
      prev_done = done;
      if (done) begin
        dcnt++;
        dcyc = c;
      end
    end
    force_en = 1'b0;
    n_checks++;
    if (dcnt !== 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d expected 1", name, dcnt);
    end
    n_checks++;
    if (dcyc !== exp_done) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got %0d expected %0d", name, dcyc, exp_done);
    end
    n_checks++;
    if (latency !== 8'(exp_lat)) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name, latency, exp_lat);
    end
    n_checks++;
    if (pass !== exp_pass) begin
      n_fail++;
      $display("FAIL %s_pass: got %b expected %b", name, pass, exp_pass);
    end
    n_checks++;
    if (pass_cnt !== 8'(exp_pc) || fail_cnt !== 8'(exp_fc)) begin
      n_fail++;
      $display("FAIL %s_counters: got %0d/%0d expected %0d/%0d", name, pass_cnt, fail_cnt,
               exp_pc, exp_fc);
    end
    n_checks++;
    if (busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_after_done: got %b expected 0", name, busy_after);
    end
  endtask

  // Runs straight after the timeout measurement, which left latency=15, pass=0
  // and fail_cnt=1.
  task automatic test_spurious_idle();
    int dcnt;
    dcnt = 0;
    force_en  = 1'b1;
    force_val = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) dcnt++;
    end
    force_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done) dcnt++;
    end
    n_checks++;
    if (fail_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL spurious_fail_cnt: got %0d expected 4", fail_cnt);
    end
    n_checks++;
    if (dcnt !== 0) begin
      n_fail++;
      $display("FAIL spurious_done: got %0d pulses expected 0", dcnt);
    end
    n_checks++;
    if (latency !== 8'd15 || pass !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_hold: got lat %0d pass %b busy %b expected 15 0 0", latency, pass,
               busy);
    end
  endtask

  // go and a spurious arrival together in IDLE, then spurious arrivals during
  // LAUNCH and REPORT around an otherwise correct 7-hop measurement.
  task automatic test_overlap();
    do_reset();
    chain_len = 7;
    go        = 1'b1;
    force_en  = 1'b1;
    force_val = 1'b1;
    tick();
    go = 1'b0;
    n_checks++;
    if (launch_out !== 1'b1 || fail_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL overlap_idle: got launch %b fail_cnt %0d expected 1 1", launch_out, fail_cnt);
    end
    tick();
    force_en = 1'b0;
    n_checks++;
    if (fail_cnt !== 8'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_launch: got fail_cnt %0d busy %b expected 2 1", fail_cnt, busy);
    end
    for (int c = 3; c <= 12; c++) begin
      tick();
      if (c == 9) begin
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || latency !== 8'd7 ||
            pass_cnt !== 8'd1 || fail_cnt !== 8'd2) begin
          n_fail++;
          $display("FAIL overlap_report: got done %b pass %b lat %0d cnt %0d/%0d expected 1 1 7 1/2",
                   done, pass, latency, pass_cnt, fail_cnt);
        end
        force_en  = 1'b1;
        force_val = 1'b1;
      end
      if (c == 10) begin
        force_en = 1'b0;
        n_checks++;
        if (done !== 1'b0 || fail_cnt !== 8'd3 || pass_cnt !== 8'd1) begin
          n_fail++;
          $display("FAIL overlap_report_spurious: got done %b cnt %0d/%0d expected 0 1/3",
                   done, pass_cnt, fail_cnt);
        end
      end
    end
  endtask

  // go held high: one measurement every HOPS+3 = 10 cycles, pass_cnt saturates.
  task automatic test_back_to_back();
    int dn;
    int last;
    int bad_gap;
    int bad_pass;
    do_reset();
    chain_len = 7;
    dn = 0;
    last = -1;
    bad_gap = 0;
    bad_pass = 0;
    go = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      tick();
      if (done) begin
        dn++;
        n_checks++;
        if ((last < 0 && c !== 9) || (last >= 0 && c - last !== 10)) begin
          n_fail++;
          bad_gap++;
          if (bad_gap < 4) $display("FAIL b2b_gap: done at cycle %0d, previous %0d, expected spacing 10", c, last);
        end
        n_checks++;
        if (pass !== 1'b1) begin
          n_fail++;
          bad_pass++;
          if (bad_pass < 4) $display("FAIL b2b_pass: got %b expected 1 at cycle %0d", pass, c);
        end
        last = c;
      end
    end
    go = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (dn !== 300) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d expected 300", dn);
    end
    n_checks++;
    if (pass_cnt !== 8'd255 || fail_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_saturation: got %0d/%0d expected 255/0", pass_cnt, fail_cnt);
    end
  endtask

  // Runs after back-to-back, so pass_cnt=255 and latency=7 before reset.
  task automatic test_reset_mid_wait();
    int dcnt;
    chain_len = 7;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got %b expected 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({launch_out, busy, done, pass} !== 4'b0000 || latency !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_async_outputs: got flags %b lat %0d expected 0000 0",
               {launch_out, busy, done, pass}, latency);
    end
    n_checks++;
    if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_async_counters: got %0d/%0d expected 0/0", pass_cnt, fail_cnt);
    end
    #1;
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 6; c <= 20; c++) begin
      tick();
      if (done) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) begin
      n_fail++;
      $display("FAIL midreset_done: got %0d pulses expected 0", dcnt);
    end
    n_checks++;
    if (fail_cnt !== 8'd1 || pass_cnt !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_inflight: got cnt %0d/%0d busy %b expected 0/1 0", pass_cnt, fail_cnt,
               busy);
    end
  endtask

  initial begin
    test_reset();
    test_measurement("match7", 7, 1'b0, 9, 7, 1'b1, 1, 0);
    test_measurement("mismatch5", 5, 1'b0, 7, 5, 1'b0, 0, 1);
    test_measurement("timeout", 7, 1'b1, 17, 15, 1'b0, 0, 1);
    test_spurious_idle();
    test_overlap();
    test_back_to_back();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
